// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Multi-cycle instruction fetch stage. Holds the PC, fetches
//               words over a req/ack handshake, presents them to decode and
//               computes branch / jump / register-jump redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  redirect_type,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic [31:0] reg_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        addr_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  localparam logic [1:0] RT_NONE   = 2'd0;
  localparam logic [1:0] RT_BRANCH = 2'd1;
  localparam logic [1:0] RT_JUMP   = 2'd2;
  localparam logic [1:0] RT_REG    = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;

  logic        fetch_done;
  logic        consume;
  logic [31:0] branch_offset;
  logic [31:0] jump_target;
  logic [31:0] reg_aligned;
  logic        reg_misaligned;
  logic [31:0] target;

  logic [31:0] imem_addr_d;
  logic        imem_req_d;
  logic [31:0] instr_d;
  logic [31:0] pc_out_d;
  logic        instr_valid_d;
  logic        addr_err_d;

  assign pc_plus4 = pc_out + 32'd4;

  // Ack only counts while a request is outstanding; FETCH always has req high.
  assign fetch_done = (state == S_FETCH) && imem_req && imem_ack;
  assign consume    = (state == S_ISSUE) && !stall;

  // Redirect target candidates; the branch shift drops bits above bit 31.
  assign branch_offset  = imm_ext << 2;
  assign jump_target    = {pc_plus4[31:28], imm_ext[25:0], 2'b00};
  assign reg_aligned    = {reg_target[31:2], 2'b00};
  assign reg_misaligned = (reg_target[1:0] != 2'b00);

  // Select the next fetch address from the redirect request.
  always_comb begin
    target = pc_plus4;
    case (redirect_type)
      RT_NONE:   target = pc_plus4;
      RT_BRANCH: target = branch_taken ? (pc_plus4 + branch_offset) : pc_plus4;
      RT_JUMP:   target = jump_target;
      RT_REG:    target = reg_aligned;
      default:   target = pc_plus4;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (fetch_done) state_next = S_ISSUE;
      S_ISSUE: if (consume) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless an event fires.
  always_comb begin
    imem_addr_d   = imem_addr;
    imem_req_d    = imem_req;
    instr_d       = instr;
    pc_out_d      = pc_out;
    instr_valid_d = instr_valid;
    addr_err_d    = 1'b0;
    case (state)
      S_IDLE: begin
        imem_addr_d = RESET_PC;
        imem_req_d  = 1'b1;
      end
      S_FETCH: begin
        if (fetch_done) begin
          instr_d       = imem_rdata;
          pc_out_d      = imem_addr;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
        end
      end
      S_ISSUE: begin
        if (consume) begin
          imem_addr_d   = target;
          imem_req_d    = 1'b1;
          instr_valid_d = 1'b0;
          addr_err_d    = (redirect_type == RT_REG) && reg_misaligned;
        end
      end
      default: begin
        imem_req_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset discards any in-flight fetch or pending consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr   <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= 32'h0;
      pc_out      <= 32'h0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      imem_addr   <= imem_addr_d;
      imem_req    <= imem_req_d;
      instr       <= instr_d;
      pc_out      <= pc_out_d;
      instr_valid <= instr_valid_d;
      addr_err    <= addr_err_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multi-cycle instruction fetch stage: holds the PC, requests words from instruction memory over a req/ack handshake, and presents the fetched instruction to decode.
- Sits directly upstream of the immediate extender, which consumes `instr`.
- Consumes the extender's 32-bit output (`imm_ext`) back from decode to compute branch and jump redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  decode not ready; hold the presented instruction.
- redirect_type  input  2  0 none, 1 conditional branch, 2 jump (J/JAL), 3 register jump (JR/JALR).
- branch_taken  input  1  branch condition result; used only when redirect_type==1.
- imm_ext  input  32  extender output: sign-extended 16-bit offset (branch) or zero-extended 26-bit target (jump).
- reg_target  input  32  register value for JR/JALR.
- imem_addr  output  32  instruction memory word address.
- imem_req  output  1  fetch request.
- imem_ack  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word.
- instr  output  32  fetched instruction; feeds the immediate extender and decode.
- pc_out  output  32  address of `instr`.
- pc_plus4  output  32  pc_out + 4, mod 2^32.
- instr_valid  output  1  `instr`/`pc_out` are valid.
- addr_err  output  1  one-cycle pulse when a JR target is misaligned.

Behaviour:
- Outputs:
  - All outputs are registered, except `pc_plus4`, which is combinational from `pc_out`.
  - Reset values: state=IDLE, imem_req=0, imem_addr=RESET_PC, instr=0, pc_out=0, instr_valid=0, addr_err=0.
  - `rst` overrides everything, including mid-fetch and mid-stall; any pending ack is discarded.
- States:
  - IDLE: next edge goes to FETCH with imem_req<=1 and imem_addr=RESET_PC.
  - FETCH: imem_req=1 and imem_addr stay stable until the ack edge. Requires imem_ack==1 on that edge, which may be the first FETCH cycle.
    - On the ack edge: instr<=imem_rdata, pc_out<=imem_addr, instr_valid<=1, imem_req<=0, go to ISSUE.
    - stall and redirect inputs are ignored in FETCH.
  - ISSUE: with stall==1, all outputs hold; redirect inputs are not sampled.
  - ISSUE, consume edge (stall==0): sample redirect_type, branch_taken, imm_ext and reg_target, compute next, then set imem_addr<=next, imem_req<=1, instr_valid<=0 and go to FETCH.
- imem_ack is ignored whenever imem_req==0.
- Next-PC rules (all arithmetic mod 2^32):
  - type 0, or type 1 with branch_taken==0: next = pc_plus4.
  - type 1 with branch_taken==1: next = pc_plus4 + (imm_ext << 2), with the shift truncated to 32 bits.
  - type 2: next = {pc_plus4[31:28], imm_ext[25:0], 2'b00}; imm_ext[31:26] are ignored.
  - type 3: next = {reg_target[31:2], 2'b00}. If reg_target[1:0]!=0, addr_err<=1 for exactly one cycle (the consume edge) and the fetch still proceeds to the aligned address.
- Boundaries:
  - pc_out=0xFFFF_FFFC sequential gives next=0x0000_0000; no error.
  - Back-to-back: minimum 2 cycles per instruction (FETCH with immediate ack, then ISSUE without stall). Throughput is therefore at most 1 instruction per 2 cycles.
  - rst asserted in the same cycle as imem_ack or a consume: reset wins.

Test Plan:
- Reset/first fetch: rst high 2 cycles then low, imem_ack tied 1 → imem_req rises 1 cycle after IDLE with imem_addr=0x0; next edge instr=imem_rdata, pc_out=0x0, instr_valid=1.
- Sequential plus stall: word at 0x40, stall=1 for 3 cycles → instr/pc_out/instr_valid held for 3 cycles. After stall drops → imem_addr=0x44, instr_valid=0.
- Branch: pc_out=0x40, type=1, taken=1, imm_ext=0xFFFF_FFFC → imem_addr=0x34. Same with taken=0 → 0x44.
- Jump: pc_out=0x1000_0010, type=2, imm_ext=0x0000_0100 → imem_addr=0x1000_0400.
- JR misaligned: type=3, reg_target=0x0000_2003 → imem_addr=0x0000_2000 and addr_err high exactly 1 cycle. Wrap case: pc_out=0xFFFF_FFFC, type 0 → imem_addr=0x0.
- Slow memory plus reset: ack delayed 4 cycles → imem_req/imem_addr stable throughout. Then assert rst during a FETCH with ack=1 → instr_valid stays 0 and all outputs return to reset values.
